// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer
// Top-level operation sequencer for the Basys3 ALU project. One button steps the
// user through loading X, Y and the opcode from the switches. The sequencer then
// starts the ALU, waits for completion (or a timeout) and captures the result,
// clamped to 13 bits, for the BCD display path.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   push         debounced button level (rising edge advances the sequence)
//   sw           switch value to be loaded
//   data         registered copy of sw, driven to the register block
//   load         one-hot load strobe: 001 = x, 010 = y, 100 = opcode
//   alu_start    one-cycle ALU start pulse
//   alu_done     ALU completion pulse
//   alu_result   ALU result, valid while alu_done = 1
//   disp_number  value sent to the BCD converter (saturated at 8191)
//   overflow     captured alu_result exceeded 8191
//   timeout_err  ALU did not complete within TIMEOUT cycles
//   state        current state code, for LEDs
//
// DATA_W must be at least 13 and at most 32.

module alu_entry_sequencer #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] data,
   output logic [2:0]        load,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   output logic [12:0]       disp_number,
   output logic              overflow,
   output logic              timeout_err,
   output logic [2:0]        state
);

   localparam logic [2:0] S_X    = 3'd0;
   localparam logic [2:0] S_Y    = 3'd1;
   localparam logic [2:0] S_OP   = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_WAIT = 3'd4;
   localparam logic [2:0] S_SHOW = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   localparam logic [12:0] DISP_MAX = 13'd8191;

   logic        push_q;
   logic        push_edge;
   logic [15:0] wait_cnt;
   logic        cnt_hit;
   logic        result_big;
   logic [12:0] result_clamped;

   assign push_edge = push & ~push_q;

   // The counter equals the number of completed S_WAIT cycles, so the error
   // state is entered exactly TIMEOUT cycles after S_WAIT was entered.
   assign cnt_hit = (wait_cnt + 16'd1) == 16'(TIMEOUT);

   always_comb begin
      result_big     = 32'(alu_result) > 32'd8191;
      result_clamped = result_big ? DISP_MAX : alu_result[12:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_X;
         data        <= '0;
         load        <= 3'b000;
         alu_start   <= 1'b0;
         disp_number <= '0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
         // A button held through reset release must not look like a press.
         push_q      <= 1'b1;
      end else begin
         push_q    <= push;
         load      <= 3'b000;
         alu_start <= 1'b0;

         case (state)
            S_X: begin
               if (push_edge) begin
                  data  <= sw;
                  load  <= 3'b001;
                  state <= S_Y;
               end
            end

            S_Y: begin
               if (push_edge) begin
                  data  <= sw;
                  load  <= 3'b010;
                  state <= S_OP;
               end
            end

            S_OP: begin
               if (push_edge) begin
                  data  <= sw;
                  load  <= 3'b100;
                  state <= S_EXEC;
               end
            end

            S_EXEC: begin
               alu_start <= 1'b1;
               wait_cnt  <= '0;
               state     <= S_WAIT;
            end

            S_WAIT: begin
               wait_cnt <= wait_cnt + 16'd1;
               // Completion takes priority over a simultaneous timeout.
               if (alu_done) begin
                  disp_number <= result_clamped;
                  overflow    <= result_big;
                  state       <= S_SHOW;
               end else if (cnt_hit) begin
                  timeout_err <= 1'b1;
                  state       <= S_ERR;
               end
            end

            S_SHOW: begin
               if (push_edge) begin
                  state <= S_X;
               end
            end

            S_ERR: begin
               if (push_edge) begin
                  timeout_err <= 1'b0;
                  state       <= S_X;
               end
            end

            default: begin
               state <= S_X;
            end
         endcase
      end
   end

endmodule
